// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits a single valid_key strobe with key = {row, col} per physical press.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       valid_key,
    output logic [3:0] key
);

    // state      | meaning
    // S_SCAN     | drive one column per dwell, sample synced rows on last dwell cycle
    // S_DEBOUNCE | column fixed, require DEBOUNCE_CYCLES stable cycles of the captured pattern
    // S_EMIT     | one-cycle valid_key strobe
    // S_RELEASE  | column fixed, wait for DEBOUNCE_CYCLES consecutive idle cycles
    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_EMIT,
        S_RELEASE
    } state_t;

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    state_t        state, state_nxt;
    logic [3:0]    row_meta, rs;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]    col_idx, col_nxt;
    logic [3:0]    pat, pat_nxt;
    logic          emit_nxt;
    logic [3:0]    key_nxt;

    function automatic logic [1:0] low_row(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!p[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign cnt_inc = (cnt >= CNT_SAT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_meta  <= 4'hF;
            rs        <= 4'hF;
            state     <= S_SCAN;
            cnt       <= '0;
            col_idx   <= 2'd0;
            pat       <= 4'hF;
            col_out   <= 4'b1110;
            valid_key <= 1'b0;
            key       <= 4'h0;
        end else begin
            row_meta  <= row_in;
            rs        <= row_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            col_idx   <= col_nxt;
            pat       <= pat_nxt;
            col_out   <= ~(4'b0001 << col_nxt);
            valid_key <= emit_nxt;
            key       <= key_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        col_nxt   = col_idx;
        pat_nxt   = pat;
        emit_nxt  = 1'b0;
        key_nxt   = key;
        case (state)
            S_SCAN: begin
                if (cnt >= SCAN_LAST) begin
                    cnt_nxt = '0;
                    if (rs == 4'hF) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        pat_nxt   = rs;
                        state_nxt = S_DEBOUNCE;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_DEBOUNCE: begin
                if (rs == 4'hF) begin
                    state_nxt = S_SCAN;
                    col_nxt   = col_idx + 2'd1;
                    cnt_nxt   = '0;
                end else if (rs != pat) begin
                    pat_nxt = rs;
                    cnt_nxt = '0;
                end else if (cnt >= DEB_LAST) begin
                    // key and strobe register together so key is valid in the strobe cycle
                    state_nxt = S_EMIT;
                    cnt_nxt   = '0;
                    emit_nxt  = 1'b1;
                    key_nxt   = {low_row(pat), col_idx};
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_EMIT: begin
                state_nxt = S_RELEASE;
                cnt_nxt   = '0;
            end
            S_RELEASE: begin
                if (rs == 4'hF) begin
                    if (cnt >= DEB_LAST) begin
                        state_nxt = S_SCAN;
                        col_nxt   = col_idx + 2'd1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 switch-matrix model drives the rows, and
// the captured strobe stream is compared against the sequence of pressed keys.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       valid_key;
    logic [3:0] key;

    logic [15:0] pressed = '0;
    logic        force_en = 1'b0;
    logic [3:0]  row_force = 4'hF;
    logic [3:0]  row_model;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    logic [3:0] pulse_key[$];
    int         pulse_cyc[$];
    logic       prev_vk = 1'b0;
    logic [3:0] prev_key = 4'h0;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .row_in    (row_in),
        .col_out   (col_out),
        .valid_key (valid_key),
        .key       (key)
    );

    always #5 clk = ~clk;

    // switch matrix: a closed key at (r,c) pulls row r low while column c is driven low
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_model[r] = 1'b0;
    end
    assign row_in = force_en ? row_force : row_model;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_vk  = 1'b0;
            prev_key = key;
        end else begin
            if (valid_key) begin
                pulse_key.push_back(key);
                pulse_cyc.push_back(cyc);
                if (prev_vk) viol++;
            end else if (key !== prev_key) begin
                viol++;
            end
            if (!$onehot(~col_out)) viol++;
            prev_vk  = valid_key;
            prev_key = key;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] c, input string tag);
        int k = 0;
        while (col_out !== c && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (col_out !== c) check(tag, {28'h0, col_out}, {28'h0, c});
    endtask

    initial begin
        int base, rel_cyc, col_bad, r_cyc, k, hold, gap;
        logic [3:0] expq[$];

        // reset with rows toggling
        rstn     = 1'b0;
        force_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            row_force = 4'($urandom_range(0, 15));
            tick(1);
        end
        check("rst_col", {28'h0, col_out}, 32'hE);
        check("rst_valid", {31'h0, valid_key}, 32'h0);
        check("rst_key", {28'h0, key}, 32'h0);
        force_en = 1'b0;

        // single press: key 4 held from reset release
        pressed[4] = 1'b1;
        rstn       = 1'b1;
        rel_cyc    = cyc;
        base       = pulse_key.size();
        col_bad    = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (col_out !== 4'b1110) col_bad++;
        end
        pressed = '0;
        tick(30);
        check("single_count", pulse_key.size() - base, 1);
        check("single_key", {28'h0, pulse_key[base]}, 32'd4);
        check("single_latency", pulse_cyc[base] - rel_cyc, (SCAN - 1) + DEB + 1);
        check("single_col_held", col_bad, 0);

        // calculator sequence
        expq = '{4'd4, 4'd0, 4'd1, 4'd3, 4'd2, 4'd5};
        base = pulse_key.size();
        foreach (expq[i]) begin
            pressed[expq[i]] = 1'b1;
            tick(30);
            pressed = '0;
            tick(30);
        end
        check("calc_count", pulse_key.size() - base, 6);
        foreach (expq[i]) check($sformatf("calc_key%0d", i), {28'h0, pulse_key[base+i]}, {28'h0, expq[i]});

        // bounce on column 3: rejected, scan wraps to column 0
        base = pulse_key.size();
        wait_col(4'b0111, "bounce_wait_col3");
        pressed[11] = 1'b1;
        tick(5);
        pressed = '0;
        k = 0;
        while (col_out === 4'b0111 && k < 40) begin
            tick(1);
            k++;
        end
        check("bounce_next_col", {28'h0, col_out}, 32'hE);
        tick(30);
        check("bounce_no_pulse", pulse_key.size() - base, 0);

        // long hold of key 15 with release chatter
        base = pulse_key.size();
        pressed[15] = 1'b1;
        tick(200);
        pressed = '0;
        tick(3);
        pressed[15] = 1'b1;
        tick(3);
        check("hold_col_before_release", {28'h0, col_out}, 32'h7);
        pressed = '0;
        r_cyc   = cyc;
        tick(2 + DEB - 1);
        check("release_col_still", {28'h0, col_out}, 32'h7);
        tick(1);
        check("release_col_next", {28'h0, col_out}, 32'hE);
        check("release_elapsed", cyc - r_cyc, 2 + DEB);
        check("hold_count", pulse_key.size() - base, 1);
        check("hold_key", {28'h0, pulse_key[base]}, 32'd15);
        tick(20);

        // rows 0 and 2 on column 1: lowest row wins
        base = pulse_key.size();
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        tick(40);
        pressed = '0;
        tick(30);
        check("two_rows_count", pulse_key.size() - base, 1);
        check("two_rows_key", {28'h0, pulse_key[base]}, 32'd1);

        // reset asserted mid-debounce on column 2
        wait_col(4'b1011, "mid_rst_wait_col2");
        pressed[2] = 1'b1;
        tick(6);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_col", {28'h0, col_out}, 32'hE);
        check("mid_rst_valid", {31'h0, valid_key}, 32'h0);
        check("mid_rst_key", {28'h0, key}, 32'h0);
        pressed = '0;
        tick(2);
        rstn = 1'b1;
        tick(20);

        // random press sequence against the expected key stream
        expq = {};
        base = pulse_key.size();
        for (int i = 0; i < 8; i++) begin
            k    = $urandom_range(0, 15);
            hold = $urandom_range(35, 60);
            gap  = $urandom_range(15, 40);
            expq.push_back(4'(k));
            pressed[k] = 1'b1;
            tick(hold);
            pressed = '0;
            tick(gap);
        end
        check("rand_count", pulse_key.size() - base, expq.size());
        foreach (expq[i])
            if (base + i < pulse_key.size())
                check($sformatf("rand_key%0d", i), {28'h0, pulse_key[base+i]}, {28'h0, expq[i]});

        check("monitor_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
